// File: rtl/hdmi_tmds_encoder.sv
// HDMI TMDS encoder: derives DE/HSYNC/VSYNC from the upscaler counters and
// emits three DVI 8b/10b symbol streams with running disparity.
module hdmi_tmds_encoder #(
  parameter logic [9:0] SCREEN_WIDTH  = 10'd720,
  parameter logic [9:0] SCREEN_HEIGHT = 10'd480,
  parameter logic [9:0] HSYNC_START   = 10'd736,
  parameter logic [9:0] HSYNC_END     = 10'd798,
  parameter logic [9:0] VSYNC_START   = 10'd489,
  parameter logic [9:0] VSYNC_END     = 10'd495,
  parameter logic       SYNC_ACTIVE   = 1'b0
) (
  input  logic        clk_h,
  input  logic        rst_h,
  input  logic [9:0]  hx,
  input  logic [9:0]  hy,
  input  logic [23:0] rgb_h,
  output logic [9:0]  tmds_ch0,
  output logic [9:0]  tmds_ch1,
  output logic [9:0]  tmds_ch2,
  output logic        de_o
);

  localparam logic [9:0] CTL_00 = 10'h354;
  localparam logic [9:0] CTL_01 = 10'h0AB;
  localparam logic [9:0] CTL_10 = 10'h154;
  localparam logic [9:0] CTL_11 = 10'h2AB;

  function automatic logic [3:0] pop8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_trans(input logic [7:0] d);
    logic [3:0] n;
    logic       xn;
    logic [8:0] q;
    n    = pop8(d);
    xn   = (n > 4'd4) || (n == 4'd4 && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    return q;
  endfunction

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00: s = CTL_00;
      2'b01: s = CTL_01;
      2'b10: s = CTL_10;
      2'b11: s = CTL_11;
    endcase
    return s;
  endfunction

  logic t_vld, t_de, t_hs, t_vs;

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      t_vld <= 1'b0;
      t_de  <= 1'b0;
      t_hs  <= ~SYNC_ACTIVE;
      t_vs  <= ~SYNC_ACTIVE;
    end else begin
      t_vld <= 1'b1;
      t_de  <= (hx < SCREEN_WIDTH) && (hy < SCREEN_HEIGHT);
      t_hs  <= (hx >= HSYNC_START && hx < HSYNC_END)
               ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      t_vs  <= (hy >= VSYNC_START && hy < VSYNC_END)
               ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  logic       s_vld, s_de;
  logic [1:0] s_ctl;

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      s_vld <= 1'b0;
      s_de  <= 1'b0;
      s_ctl <= {~SYNC_ACTIVE, ~SYNC_ACTIVE};
      de_o  <= 1'b0;
    end else begin
      s_vld <= t_vld;
      s_de  <= t_de;
      s_ctl <= {t_vs, t_hs};
      de_o  <= s_vld && s_de;
    end
  end

  logic [7:0] byte_in [3];
  logic [9:0] sym     [3];

  assign byte_in[0] = rgb_h[7:0];
  assign byte_in[1] = rgb_h[15:8];
  assign byte_in[2] = rgb_h[23:16];

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [8:0]        qm_d, qm;
    logic [3:0]        n1, n0;
    logic [1:0]        ctl;
    logic signed [4:0] cnt, cnt_nx, diff, two_q, two_nq;
    logic [9:0]        sym_q, sym_nx;

    assign qm_d = min_trans(byte_in[c]);
    assign ctl  = (c == 0) ? s_ctl : 2'b00;

    always_ff @(posedge clk_h or negedge rst_h) begin
      if (!rst_h) begin
        qm <= '0;
        n1 <= '0;
        n0 <= '0;
      end else begin
        qm <= qm_d;
        n1 <= pop8(qm_d[7:0]);
        n0 <= 4'd8 - pop8(qm_d[7:0]);
      end
    end

    assign diff   = $signed({1'b0, n1}) - $signed({1'b0, n0});
    assign two_q  = qm[8] ? 5'sd2 : 5'sd0;
    assign two_nq = qm[8] ? 5'sd0 : 5'sd2;

    // Pipeline not yet filled: hold the reset symbol and zero disparity
    always_comb begin
      sym_nx = CTL_00;
      cnt_nx = '0;
      if (!s_vld) begin
        sym_nx = CTL_00;
      end else if (!s_de) begin
        sym_nx = ctl_sym(ctl);
      end else if (cnt == 0 || n1 == n0) begin
        sym_nx = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_nx = qm[8] ? cnt + diff : cnt - diff;
      end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
        sym_nx = {1'b1, qm[8], ~qm[7:0]};
        cnt_nx = cnt + two_q - diff;
      end else begin
        sym_nx = {1'b0, qm[8], qm[7:0]};
        cnt_nx = cnt - two_nq + diff;
      end
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
      if (!rst_h) begin
        sym_q <= CTL_00;
        cnt   <= '0;
      end else begin
        sym_q <= sym_nx;
        cnt   <= cnt_nx;
      end
    end

    assign sym[c] = sym_q;
  end

  assign tmds_ch0 = sym[0];
  assign tmds_ch1 = sym[1];
  assign tmds_ch2 = sym[2];

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder: directed symbols, control codes,
// reset behaviour and a decoded random line.
module tb_hdmi_tmds_encoder;

  localparam int K_NONE = 0;
  localparam int K_EXACT = 1;
  localparam int K_DEC = 2;

  typedef struct {
    int          due;
    int          kind;
    logic [9:0]  e0, e1, e2;
    logic        ede;
    logic [23:0] rgb;
  } ent_t;

  logic        clk_h = 1'b0;
  logic        rst_h = 1'b0;
  logic [9:0]  hx = '0;
  logic [9:0]  hy = '0;
  logic [23:0] rgb_h = '0;
  logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2;
  logic        de_o;

  hdmi_tmds_encoder dut (
    .clk_h    (clk_h),
    .rst_h    (rst_h),
    .hx       (hx),
    .hy       (hy),
    .rgb_h    (rgb_h),
    .tmds_ch0 (tmds_ch0),
    .tmds_ch1 (tmds_ch1),
    .tmds_ch2 (tmds_ch2),
    .de_o     (de_o)
  );

  always #5 clk_h = ~clk_h;

  int cyc = 0;
  always @(posedge clk_h) cyc <= cyc + 1;

  ent_t        q[$];
  logic [23:0] pend = '0;
  logic        fin = 1'b0;
  logic        count_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          de_cnt = 0;
  int          disp [3];

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++)
      o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic push(input int due, input logic [9:0] e0,
                      input logic [9:0] e1, input logic [9:0] e2,
                      input logic ede);
    ent_t e;
    e.due = due; e.kind = K_EXACT;
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.ede = ede; e.rgb = '0;
    q.push_back(e);
  endtask

  // rgb_h lags hx/hy by one clock, so each call drives the previous pixel
  task automatic pix(input logic [9:0] x, input logic [9:0] y,
                     input logic [23:0] rgb, input int kind,
                     input logic [9:0] e0, input logic [9:0] e1,
                     input logic [9:0] e2, input logic ede);
    ent_t e;
    hx = x; hy = y;
    rgb_h = pend;
    pend = rgb;
    if (kind != K_NONE) begin
      e.due = cyc + 3; e.kind = kind;
      e.e0 = e0; e.e1 = e1; e.e2 = e2; e.ede = ede; e.rgb = rgb;
      q.push_back(e);
    end
    @(posedge clk_h); #1;
  endtask

  always @(negedge clk_h) begin
    ent_t        e;
    logic [23:0] got;
    int          mx;
    disp[0] = de_o ? disp[0] + 2 * $countones(tmds_ch0) - 10 : 0;
    disp[1] = de_o ? disp[1] + 2 * $countones(tmds_ch1) - 10 : 0;
    disp[2] = de_o ? disp[2] + 2 * $countones(tmds_ch2) - 10 : 0;
    if (count_en && de_o) de_cnt++;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++;
        $display("FAIL late_entry due=%0d now=%0d", e.due, cyc);
      end else if (e.kind == K_EXACT) begin
        if ({tmds_ch0, tmds_ch1, tmds_ch2, de_o} !==
            {e.e0, e.e1, e.e2, e.ede}) begin
          failures++;
          $display("FAIL symbols cyc=%0d got=%h/%h/%h de=%b exp=%h/%h/%h de=%b",
                   cyc, tmds_ch0, tmds_ch1, tmds_ch2, de_o,
                   e.e0, e.e1, e.e2, e.ede);
        end
      end else begin
        got = {dec(tmds_ch2), dec(tmds_ch1), dec(tmds_ch0)};
        if (got !== e.rgb || de_o !== 1'b1) begin
          failures++;
          $display("FAIL decode cyc=%0d got=%h de=%b exp=%h de=1",
                   cyc, got, de_o, e.rgb);
        end
        mx = 0;
        for (int c = 0; c < 3; c++)
          if ((disp[c] < 0 ? -disp[c] : disp[c]) > mx)
            mx = disp[c] < 0 ? -disp[c] : disp[c];
        checks++;
        if (mx > 10) begin
          failures++;
          $display("FAIL disparity cyc=%0d got=%0d limit=10", cyc, mx);
        end
      end
    end
    if (fin) begin
      checks++;
      if (de_cnt != 720) begin
        failures++;
        $display("FAIL de_count got=%0d exp=720", de_cnt);
      end
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL queue_drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with hx=hy=0
    push(1, 10'h354, 10'h354, 10'h354, 1'b0);
    push(2, 10'h354, 10'h354, 10'h354, 1'b0);
    push(3, 10'h354, 10'h354, 10'h354, 1'b0);
    repeat (3) begin
      @(posedge clk_h); #1;
    end
    rst_h = 1'b1;
    push(cyc + 1, 10'h354, 10'h354, 10'h354, 1'b0);
    push(cyc + 2, 10'h354, 10'h354, 10'h354, 1'b0);
    // Black x3: disparity -8, +2, -6
    pix(0, 0, 24'h000000, K_EXACT, 10'h100, 10'h100, 10'h100, 1'b1);
    pix(1, 0, 24'h000000, K_EXACT, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
    pix(2, 0, 24'h000000, K_EXACT, 10'h100, 10'h100, 10'h100, 1'b1);
    // Control codes and out-of-frame counters
    pix(800, 0, 24'h0, K_EXACT, 10'h2AB, 10'h354, 10'h354, 1'b0);
    pix(740, 490, 24'h0, K_EXACT, 10'h354, 10'h354, 10'h354, 1'b0);
    pix(740, 0, 24'h0, K_EXACT, 10'h154, 10'h354, 10'h354, 1'b0);
    pix(800, 490, 24'h0, K_EXACT, 10'h0AB, 10'h354, 10'h354, 1'b0);
    pix(1000, 0, 24'h0, K_EXACT, 10'h2AB, 10'h354, 10'h354, 1'b0);
    pix(5, 600, 24'h0, K_EXACT, 10'h2AB, 10'h354, 10'h354, 1'b0);
    // Balanced q_m, then white run up to the end of the active line
    pix(10, 5, 24'h555555, K_EXACT, 10'h133, 10'h133, 10'h133, 1'b1);
    pix(717, 5, 24'hFFFFFF, K_EXACT, 10'h200, 10'h200, 10'h200, 1'b1);
    pix(718, 5, 24'hFFFFFF, K_EXACT, 10'h0FF, 10'h0FF, 10'h0FF, 1'b1);
    pix(719, 5, 24'hFFFFFF, K_EXACT, 10'h0FF, 10'h0FF, 10'h0FF, 1'b1);
    pix(720, 5, 24'hFFFFFF, K_EXACT, 10'h2AB, 10'h354, 10'h354, 1'b0);
    // New line must start from zero disparity
    pix(0, 6, 24'h000000, K_EXACT, 10'h100, 10'h100, 10'h100, 1'b1);
    pix(1, 6, 24'hFFFFFF, K_EXACT, 10'h0FF, 10'h0FF, 10'h0FF, 1'b1);
    pix(2, 6, 24'hFFFFFF, K_EXACT, 10'h0FF, 10'h0FF, 10'h0FF, 1'b1);
    for (int i = 0; i < 5; i++)
      pix(10'(100 + i), 20, 24'h123456, K_NONE, '0, '0, '0, 1'b0);
    // Mid-frame reset
    rst_h = 1'b0;
    push(cyc, 10'h354, 10'h354, 10'h354, 1'b0);
    push(cyc + 1, 10'h354, 10'h354, 10'h354, 1'b0);
    pix(200, 20, 24'h0, K_NONE, '0, '0, '0, 1'b0);
    rst_h = 1'b1;
    pend = '0;
    count_en = 1'b1;
    // One full random line
    for (int x = 0; x < 858; x++) begin
      if (x < 720)
        pix(10'(x), 10, 24'($urandom), K_DEC, '0, '0, '0, 1'b1);
      else if (x >= 736 && x < 798)
        pix(10'(x), 10, 24'h0, K_EXACT, 10'h154, 10'h354, 10'h354, 1'b0);
      else
        pix(10'(x), 10, 24'h0, K_EXACT, 10'h2AB, 10'h354, 10'h354, 1'b0);
    end
    for (int i = 0; i < 4; i++)
      pix(800, 11, 24'h0, K_NONE, '0, '0, '0, 1'b0);
    fin = 1'b1;
  end

endmodule
